vis_frame_sequencer: RTL and testbench

- Sequences one audio frame through the linear visualizer datapath: amplitude preprocessing, hue calculation, LED-count calculation, color calculation, then the LED output driver.
- Sits between the upstream note-bin producer and the visualizer stages. Replaces the tied-off start with real start/done handshakes.
- Enforces per-phase timeouts and counts frames that arrive while busy.

---
 rtl/vis_frame_sequencer_if.sv | 36 +++
 rtl/vis_frame_sequencer.sv | 137 +++++++++++++
 tb/tb_vis_frame_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/vis_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer and the upstream producer / visualizer stages.
// master is the sequencer side; slave is the producer/stage side.
interface vis_frame_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             frame_valid_i;
    logic             frame_ready_o;
    logic             latch_o;
    logic             amp_start_o;
    logic             amp_done_i;
    logic             hue_start_o;
    logic             hue_done_i;
    logic             count_start_o;
    logic             count_done_i;
    logic             color_start_o;
    logic             color_done_i;
    logic             led_start_o;
    logic             led_done_i;
    logic             busy_o;
    logic [1:0]       phase_o;
    logic             timeout_o;
    logic [CNT_W-1:0] frames_done_o;
    logic [CNT_W-1:0] frames_dropped_o;

    modport master (
        input  frame_valid_i, amp_done_i, hue_done_i, count_done_i, color_done_i, led_done_i,
        output frame_ready_o, latch_o, amp_start_o, hue_start_o, count_start_o, color_start_o,
        output led_start_o, busy_o, phase_o, timeout_o, frames_done_o, frames_dropped_o
    );

    modport slave (
        output frame_valid_i, amp_done_i, hue_done_i, count_done_i, color_done_i, led_done_i,
        input  frame_ready_o, latch_o, amp_start_o, hue_start_o, count_start_o, color_start_o,
        input  led_start_o, busy_o, phase_o, timeout_o, frames_done_o, frames_dropped_o
    );
endinterface

// File: rtl/vis_frame_sequencer.sv
// Walks one audio frame through preprocess -> map -> LED phases with start/done handshakes,
// per-phase timeouts, a completed-frame counter and a saturating dropped-frame counter.
module vis_frame_sequencer #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = 8
) (
    input logic                   clk,
    input logic                   rst,
    vis_frame_sequencer_if.master bus
);
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
    localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPre  = 2'd1,
        StMap  = 2'd2,
        StLed  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic             seen_a_q, seen_a_d;
    logic             seen_b_q, seen_b_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic first_cycle;
    logic expired;
    logic done_a, done_b;
    logic hit_a, hit_b;
    logic complete;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            tmr_q      <= '0;
            seen_a_q   <= 1'b0;
            seen_b_q   <= 1'b0;
            timeout_q  <= 1'b0;
            done_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            seen_a_q   <= seen_a_d;
            seen_b_q   <= seen_b_d;
            timeout_q  <= timeout_d;
            done_cnt_q <= done_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        first_cycle = (tmr_q == '0);
        expired     = (tmr_q == TmrMax);
        done_a      = 1'b0;
        done_b      = 1'b0;
        // The LED phase has a single done; its second slot is treated as always present.
        case (state_q)
            StPre: begin
                done_a = bus.amp_done_i;
                done_b = bus.hue_done_i;
            end
            StMap: begin
                done_a = bus.count_done_i;
                done_b = bus.color_done_i;
            end
            StLed: begin
                done_a = bus.led_done_i;
                done_b = 1'b1;
            end
            default: ;
        endcase
        // Dones during the start cycle belong to a previous request and are ignored.
        hit_a    = done_a & ~first_cycle;
        hit_b    = done_b & ~first_cycle;
        complete = (seen_a_q | hit_a) & (seen_b_q | hit_b);

        state_d    = state_q;
        tmr_d      = tmr_q + TmrW'(1);
        seen_a_d   = seen_a_q | hit_a;
        seen_b_d   = seen_b_q | hit_b;
        timeout_d  = timeout_q;
        done_cnt_d = done_cnt_q;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            StIdle: begin
                tmr_d = '0;
                if (bus.frame_valid_i) state_d = StPre;
            end
            StPre, StMap, StLed: begin
                if (complete) begin
                    unique case (state_q)
                        StPre:   state_d = StMap;
                        StMap:   state_d = StLed;
                        default: begin
                            state_d    = StIdle;
                            done_cnt_d = done_cnt_q + CNT_W'(1);
                        end
                    endcase
                end else if (expired) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            tmr_d    = '0;
            seen_a_d = 1'b0;
            seen_b_d = 1'b0;
        end

        if (bus.frame_valid_i && state_q != StIdle && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        bus.frame_ready_o    = (state_q == StIdle);
        bus.latch_o          = (state_q == StIdle) & bus.frame_valid_i;
        bus.amp_start_o      = (state_q == StPre) & first_cycle;
        bus.hue_start_o      = (state_q == StPre) & first_cycle;
        bus.count_start_o    = (state_q == StMap) & first_cycle;
        bus.color_start_o    = (state_q == StMap) & first_cycle;
        bus.led_start_o      = (state_q == StLed) & first_cycle;
        bus.busy_o           = (state_q != StIdle);
        bus.phase_o          = state_q;
        bus.timeout_o        = timeout_q;
        bus.frames_done_o    = done_cnt_q;
        bus.frames_dropped_o = drop_cnt_q;
    end
endmodule

// File: tb/tb_vis_frame_sequencer.sv
// Directed bench for vis_frame_sequencer with TIMEOUT = 8 and CNT_W = 3.
module tb_vis_frame_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    vis_frame_sequencer_if #(.CNT_W(3)) bus ();

    vis_frame_sequencer #(
        .TIMEOUT(8),
        .CNT_W  (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Inputs are driven 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic accept_frame(input logic hold);
        tick();
        bus.frame_valid_i = 1'b1;
        #1;
        checks++; if (bus.frame_ready_o !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b want 1", bus.frame_ready_o); end
        checks++; if (bus.latch_o !== 1'b1) begin errors++; $display("FAIL accept_latch: got %b want 1", bus.latch_o); end
        tick();
        bus.frame_valid_i = hold;
        #1;
        checks++; if (bus.phase_o !== 2'd1) begin errors++; $display("FAIL pre_entry_phase: got %0d want 1", bus.phase_o); end
        checks++; if ({bus.amp_start_o, bus.hue_start_o} !== 2'b11) begin errors++; $display("FAIL pre_starts: got %b want 11", {bus.amp_start_o, bus.hue_start_o}); end
        checks++; if ({bus.latch_o, bus.busy_o} !== 2'b01) begin errors++; $display("FAIL pre_latch_busy: got %b want 01", {bus.latch_o, bus.busy_o}); end
    endtask

    task automatic pre_fast();
        tick();
        bus.amp_done_i = 1'b1;
        bus.hue_done_i = 1'b1;
        #1;
        checks++; if ({bus.phase_o, bus.amp_start_o} !== 3'b010) begin errors++; $display("FAIL pre_second_cycle: got %b want 010", {bus.phase_o, bus.amp_start_o}); end
        tick();
        bus.amp_done_i = 1'b0;
        bus.hue_done_i = 1'b0;
        #1;
        checks++; if (bus.phase_o !== 2'd2) begin errors++; $display("FAIL map_entry_phase: got %0d want 2", bus.phase_o); end
        checks++; if ({bus.count_start_o, bus.color_start_o} !== 2'b11) begin errors++; $display("FAIL map_starts: got %b want 11", {bus.count_start_o, bus.color_start_o}); end
    endtask

    task automatic map_fast();
        tick();
        bus.count_done_i = 1'b1;
        bus.color_done_i = 1'b1;
        #1;
        tick();
        bus.count_done_i = 1'b0;
        bus.color_done_i = 1'b0;
        #1;
        checks++; if ({bus.phase_o, bus.led_start_o} !== 3'b111) begin errors++; $display("FAIL led_entry: got %b want 111", {bus.phase_o, bus.led_start_o}); end
    endtask

    task automatic led_fast();
        tick();
        bus.led_done_i = 1'b1;
        #1;
        checks++; if ({bus.phase_o, bus.led_start_o, bus.frame_ready_o} !== 4'b1100) begin errors++; $display("FAIL led_second_cycle: got %b want 1100", {bus.phase_o, bus.led_start_o, bus.frame_ready_o}); end
        tick();
        bus.led_done_i    = 1'b0;
        bus.frame_valid_i = 1'b0;
        #1;
        checks++; if ({bus.phase_o, bus.frame_ready_o, bus.busy_o} !== 4'b0010) begin errors++; $display("FAIL back_to_idle: got %b want 0010", {bus.phase_o, bus.frame_ready_o, bus.busy_o}); end
    endtask

    task automatic good_frame(input logic [2:0] exp_done, input logic hold);
        accept_frame(hold);
        pre_fast();
        map_fast();
        led_fast();
        checks++; if (bus.frames_done_o !== exp_done) begin errors++; $display("FAIL frames_done: got %0d want %0d", bus.frames_done_o, exp_done); end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++; if ({bus.latch_o, bus.amp_start_o, bus.hue_start_o, bus.count_start_o, bus.color_start_o, bus.led_start_o} !== 6'b0) begin errors++; $display("FAIL reset_pulses: got %b want 000000", {bus.latch_o, bus.amp_start_o, bus.hue_start_o, bus.count_start_o, bus.color_start_o, bus.led_start_o}); end
        checks++; if ({bus.busy_o, bus.timeout_o, bus.phase_o} !== 4'b0) begin errors++; $display("FAIL reset_status: got %b want 0000", {bus.busy_o, bus.timeout_o, bus.phase_o}); end
        checks++; if ({bus.frames_done_o, bus.frames_dropped_o} !== 6'b0) begin errors++; $display("FAIL reset_counters: got %b want 000000", {bus.frames_done_o, bus.frames_dropped_o}); end
        repeat (2) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        checks++; if (bus.frame_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.frame_ready_o); end
    endtask

    task automatic test_basic_frame();
        repeat (3) tick();
        good_frame(3'd1, 1'b0);
        checks++; if (bus.frames_dropped_o !== 3'd0) begin errors++; $display("FAIL basic_drops: got %0d want 0", bus.frames_dropped_o); end
    endtask

    task automatic test_skewed();
        accept_frame(1'b0);
        tick();
        bus.amp_done_i = 1'b1;
        #1;
        checks++; if (bus.phase_o !== 2'd1) begin errors++; $display("FAIL skew_s1_phase: got %0d want 1", bus.phase_o); end
        tick();
        bus.amp_done_i = 1'b0;
        #1;
        checks++; if ({bus.phase_o, bus.amp_start_o} !== 3'b010) begin errors++; $display("FAIL skew_s2: got %b want 010", {bus.phase_o, bus.amp_start_o}); end
        tick();
        #1;
        checks++; if ({bus.phase_o, bus.amp_start_o} !== 3'b010) begin errors++; $display("FAIL skew_s3: got %b want 010", {bus.phase_o, bus.amp_start_o}); end
        tick();
        bus.hue_done_i = 1'b1;
        #1;
        checks++; if ({bus.phase_o, bus.amp_start_o} !== 3'b010) begin errors++; $display("FAIL skew_s4: got %b want 010", {bus.phase_o, bus.amp_start_o}); end
        tick();
        bus.hue_done_i = 1'b0;
        #1;
        checks++; if ({bus.phase_o, bus.count_start_o} !== 3'b101) begin errors++; $display("FAIL skew_map_entry: got %b want 101", {bus.phase_o, bus.count_start_o}); end
        map_fast();
        led_fast();
        checks++; if (bus.frames_done_o !== 3'd2) begin errors++; $display("FAIL skew_frames: got %0d want 2", bus.frames_done_o); end
    endtask

    task automatic test_done_at_timeout();
        accept_frame(1'b0);
        pre_fast();
        tick();
        bus.color_done_i = 1'b1;
        #1;
        tick();
        bus.color_done_i = 1'b0;
        repeat (6) tick();
        bus.count_done_i = 1'b1;
        #1;
        checks++; if (bus.phase_o !== 2'd2) begin errors++; $display("FAIL edge_last_cycle_phase: got %0d want 2", bus.phase_o); end
        tick();
        bus.count_done_i = 1'b0;
        #1;
        checks++; if ({bus.phase_o, bus.timeout_o} !== 3'b110) begin errors++; $display("FAIL edge_success: got %b want 110", {bus.phase_o, bus.timeout_o}); end
        led_fast();
        checks++; if (bus.frames_done_o !== 3'd3) begin errors++; $display("FAIL edge_frames: got %0d want 3", bus.frames_done_o); end
    endtask

    task automatic test_start_ignored();
        accept_frame(1'b0);
        bus.amp_done_i = 1'b1;
        bus.hue_done_i = 1'b1;
        #1;
        tick();
        bus.amp_done_i = 1'b0;
        bus.hue_done_i = 1'b0;
        #1;
        checks++; if (bus.phase_o !== 2'd1) begin errors++; $display("FAIL ignore_s1_phase: got %0d want 1", bus.phase_o); end
        repeat (7) tick();
        #1;
        checks++; if ({bus.phase_o, bus.timeout_o} !== 3'b010) begin errors++; $display("FAIL ignore_s8: got %b want 010", {bus.phase_o, bus.timeout_o}); end
        tick();
        #1;
        checks++; if ({bus.phase_o, bus.timeout_o} !== 3'b001) begin errors++; $display("FAIL ignore_abort: got %b want 001", {bus.phase_o, bus.timeout_o}); end
        checks++; if (bus.frames_done_o !== 3'd3) begin errors++; $display("FAIL ignore_frames: got %0d want 3", bus.frames_done_o); end
    endtask

    task automatic test_timeout();
        accept_frame(1'b0);
        pre_fast();
        tick();
        bus.color_done_i = 1'b1;
        #1;
        tick();
        bus.color_done_i = 1'b0;
        repeat (6) tick();
        #1;
        checks++; if (bus.phase_o !== 2'd2) begin errors++; $display("FAIL to_last_cycle_phase: got %0d want 2", bus.phase_o); end
        tick();
        bus.count_done_i = 1'b1;
        #1;
        checks++; if ({bus.phase_o, bus.timeout_o, bus.busy_o} !== 4'b0010) begin errors++; $display("FAIL to_abort: got %b want 0010", {bus.phase_o, bus.timeout_o, bus.busy_o}); end
        tick();
        bus.count_done_i = 1'b0;
        #1;
        checks++; if ({bus.phase_o, bus.frames_done_o} !== 5'b00011) begin errors++; $display("FAIL to_late_done: got %b want 00011", {bus.phase_o, bus.frames_done_o}); end
        good_frame(3'd4, 1'b0);
        checks++; if (bus.timeout_o !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", bus.timeout_o); end
    endtask

    task automatic test_drops();
        checks++; if (bus.frames_dropped_o !== 3'd0) begin errors++; $display("FAIL drops_start: got %0d want 0", bus.frames_dropped_o); end
        good_frame(3'd5, 1'b1);
        checks++; if (bus.frames_dropped_o !== 3'd6) begin errors++; $display("FAIL drops_one_frame: got %0d want 6", bus.frames_dropped_o); end
        good_frame(3'd6, 1'b1);
        checks++; if (bus.frames_dropped_o !== 3'd7) begin errors++; $display("FAIL drops_saturate: got %0d want 7", bus.frames_dropped_o); end
    endtask

    task automatic test_reset_mid();
        accept_frame(1'b0);
        pre_fast();
        #2 rst = 1'b0;
        #1;
        checks++; if ({bus.count_start_o, bus.color_start_o, bus.busy_o, bus.phase_o} !== 5'b0) begin errors++; $display("FAIL midreset_outputs: got %b want 00000", {bus.count_start_o, bus.color_start_o, bus.busy_o, bus.phase_o}); end
        checks++; if ({bus.timeout_o, bus.frames_done_o, bus.frames_dropped_o} !== 7'b0) begin errors++; $display("FAIL midreset_state: got %b want 0000000", {bus.timeout_o, bus.frames_done_o, bus.frames_dropped_o}); end
        checks++; if (bus.frame_ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", bus.frame_ready_o); end
        @(negedge clk);
        rst = 1'b1;
        good_frame(3'd1, 1'b0);
    endtask

    initial begin
        bus.frame_valid_i = 1'b0;
        bus.amp_done_i    = 1'b0;
        bus.hue_done_i    = 1'b0;
        bus.count_done_i  = 1'b0;
        bus.color_done_i  = 1'b0;
        bus.led_done_i    = 1'b0;
        test_reset();
        test_basic_frame();
        test_skewed();
        test_done_at_timeout();
        test_start_ignored();
        test_timeout();
        test_drops();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
